avln_st_arbiter: RTL and testbench
==================================

# avln_st_arbiter

Packet-granular round-robin arbiter that shares a single Avalon-ST sink, such as the `seaccow_internal` `in` port, between N_IN `avln_st` sources. It grants one source from `sop` to `eop` and forwards beats through one output register. It discards stray mid-packet beats and truncates packets that exceed a length limit. Saturating error counters report both events.

## Interface
- `N_IN`, default 4: number of requesting sources, minimum 2.
- `MAX_BEATS`, default 1024: maximum forwarded beats per packet, minimum 1.
- `CNT_W`, default 16: width of the status counters.
- `sys_clk` input, 1 bit: single clock.
- `reset` input, 1 bit: reset is synchronous and active-high.
- `in` input, `avln_st [N_IN]`: source streams carrying `data`, `sop`, `eop`, `empty` and `valid`.
- `in_ready` output, `[N_IN]`: per-source accept. A beat transfers on a cycle with `in[i].valid && in_ready[i]`.
- `out` output, `avln_st`: registered merged stream.
- `out_ready` input, 1 bit: downstream accept. Tie it to 1 for sinks without backpressure.
- `grant_idx` output, `$clog2(N_IN)` bits: currently or last granted source.
- `busy` output, 1 bit: state is not ARB_IDLE.
- `err_count` output, `CNT_W` bits: saturating count of discarded stray beats and stripped mid-packet `sop`s.
- `trunc_count` output, `CNT_W` bits: saturating count of truncated packets.

## Operation
- **States:** ARB_IDLE, ARB_BUSY, ARB_FLUSH.
- **ARB_IDLE:**
  - Candidates are the sources with `valid && sop`.
  - The search starts at `rr_ptr` and wraps at N_IN. The first candidate found becomes `cur`.
  - On that edge: `grant_idx` = `cur`, `rr_ptr` = `(cur+1) mod N_IN`, state goes to ARB_BUSY, beat counter = 0.
  - No beat is accepted from the winner in ARB_IDLE.
  - A source with `valid && !sop` gets `in_ready=1`; its beat is discarded and `err_count` increments once per beat.
  - Several stray beats on one cycle add their total count, saturating.
- **ARB_BUSY:**
  - `in_ready[cur] = !out.valid || out_ready`. All other `in_ready` are 0.
  - Each accepted beat loads the output register and increments the beat counter.
  - A `sop` on any beat after the first is cleared on `out` and increments `err_count`.
  - Accepted beat with `eop`: go to ARB_IDLE.
  - Accepted beat without `eop` that is beat number MAX_BEATS: forward it with `eop` forced to 1 and `empty` forced to 0, increment `trunc_count`, go to ARB_FLUSH.
- **ARB_FLUSH:**
  - `in_ready[cur]=1` unconditionally. Beats are discarded and `out` is not loaded.
  - Accepted beat with `eop`: go to ARB_IDLE.
- **Output register:**
  - `out.valid` clears when `out_ready` is high and no new beat loads.
  - Output contents hold while `out.valid && !out_ready`.
- **Single-beat packet:** a beat with `sop` and `eop` together goes ARB_BUSY to ARB_IDLE on acceptance.
- **Counters:** both stop at `2^CNT_W-1` and never wrap.
- **Reset:**
  - Values: `out.valid`=0, other `out` fields 0, `in_ready`=0, state ARB_IDLE, `rr_ptr`=0, `grant_idx`=0, `busy`=0, both counters 0.
  - Reset mid-packet abandons the packet without emitting `eop`. The remainder of that packet is then treated as stray beats.

## Timing
- Grant to first accept: an ARB_IDLE edge selects the winner; its first beat can be accepted on the next cycle.
- Latency: an accepted beat appears on `out` one cycle later.
- Throughput: 1 beat/cycle within a packet while `out_ready` stays high.
- Minimum packet gap: one ARB_IDLE cycle between consecutive packets, from any sources.
- Stall: with `out_ready` low and `out.valid` high, `in_ready[cur]` is 0 in the same cycle (combinational path from `out_ready`).
- Boundary:
  - The ARB_BUSY-to-ARB_IDLE edge and a new candidate's `sop` arriving together: the new candidate is arbitrated on the following ARB_IDLE cycle, not on that edge.
  - The `rr_ptr` update uses mod N_IN, so N_IN need not be a power of two.

## Structure
- `global_types`: add `arb_state_t` (ARB_IDLE, ARB_BUSY, ARB_FLUSH).
- `avln_st` is used unchanged.
- Sub-module `rr_picker`:
  - Parameter: N_IN.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and `idx`.
  - Combinational rotate, priority-encode, un-rotate.
- The FSM, beat counter (`$clog2(MAX_BEATS+1)` bits), output register and status counters live in `avln_st_arbiter`.

## Test plan
- **Round-robin:** sources 0 and 2 each hold a 3-beat packet ready at reset release. `out` carries source 0's packet, then source 2's. `grant_idx` goes 0 then 2. There is one idle cycle between the packets.
- **Backpressure:** a 4-beat packet with `out_ready` low for 3 cycles after beat 2. `out` holds beat 2 stable and `in_ready[cur]`=0. The packet completes intact, 4 beats in order.
- **Truncation:** MAX_BEATS=4, source 1 sends a 7-beat packet. `out` shows 4 beats with the 4th carrying `eop`=1 and `empty`=0. Beats 5-7 are consumed and not forwarded. `trunc_count`=1. The next packet arbitrates normally.
- **Stray and mid-packet sop:** source 3 sends 2 beats with `valid=1`, `sop=0` in ARB_IDLE, then a packet with a second `sop` on beat 3. `err_count`=3 and `out` beat 3 has `sop=0`.
- **Single-beat packets:** back-to-back on all 4 sources, each beat with `sop=eop=1`. `out` order is 0,1,2,3, each followed by one idle cycle.
- **Reset:** reset asserted mid-packet. Next cycle `out.valid=0`, `busy=0`, counters 0. The tail of the interrupted packet increments `err_count` per beat.

Source files
------------

// File: rtl/avln_st_arbiter_pkg.sv
// Shared types for the Avalon-ST packet arbiter: the stream beat and the arbiter FSM states.
package avln_st_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic               valid;
  } avln_st;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_FLUSH = 2'd2
  } arb_state_t;

endpackage

// File: rtl/avln_st_arbiter_rr_picker.sv
// Round-robin picker: rotates the request vector to start at i_rr_ptr, takes the lowest
// set bit and maps it back to a source index (mod N_IN, so any N_IN >= 2 works).
module avln_st_arbiter_rr_picker #(
  parameter  int N_IN = 4,
  localparam int PW   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic            o_found,
  output logic [PW-1:0]   o_idx
);
  logic [N_IN-1:0] w_rot;
  logic [PW-1:0]   w_off;
  logic [PW:0]     w_sum;

  assign w_rot = N_IN'({i_req, i_req} >> i_rr_ptr);

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int j = N_IN - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        w_off   = PW'(j);
      end
    end
  end

  assign w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (PW + 1)'(N_IN)) ? PW'(w_sum - (PW + 1)'(N_IN)) : PW'(w_sum);

endmodule

// File: rtl/avln_st_arbiter.sv
// Packet-granular round-robin arbiter: N_IN Avalon-ST sources share one sink through a
// single output register, with stray-beat discard, length truncation and error counters.
module avln_st_arbiter
  import avln_st_arbiter_pkg::*;
#(
  parameter  int N_IN      = 4,
  parameter  int MAX_BEATS = 1024,
  parameter  int CNT_W     = 16,
  localparam int PW        = $clog2(N_IN),
  localparam int BW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  avln_st           in [N_IN],
  output logic [N_IN-1:0]  in_ready,
  output avln_st           out,
  input  logic             out_ready,
  output logic [PW-1:0]    grant_idx,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] trunc_count
);
  localparam int SW = CNT_W + PW + 1;

  arb_state_t       r_state;
  logic [PW-1:0]    r_rr_ptr;
  logic [PW-1:0]    r_grant;
  logic [BW-1:0]    r_beat;
  avln_st           r_out;
  logic             r_busy;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_trunc;

  logic [N_IN-1:0]  w_req;
  logic [N_IN-1:0]  w_stray;
  logic             w_found;
  logic [PW-1:0]    w_pick;
  logic [PW-1:0]    w_pick_next;
  avln_st           w_cur;
  avln_st           w_beat;
  logic             w_accept;
  logic             w_load;
  logic             w_last;
  logic             w_mid_sop;
  logic [PW:0]      w_stray_cnt;
  logic [PW:0]      w_err_inc;
  logic [SW-1:0]    w_err_sum;
  logic [CNT_W-1:0] w_err_next;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_req
    assign w_req[gi]   = in[gi].valid &&  in[gi].sop;
    assign w_stray[gi] = in[gi].valid && !in[gi].sop;
  end

  avln_st_arbiter_rr_picker #(.N_IN(N_IN)) u_picker (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  assign w_pick_next = (w_pick == PW'(N_IN - 1)) ? '0 : w_pick + 1'b1;

  // Idle swallows stray (non-sop) beats from every source; a winner is only granted here.
  always_comb begin
    in_ready = '0;
    if (!reset) begin
      case (r_state)
        ARB_IDLE:  in_ready = w_stray;
        ARB_BUSY:  in_ready[r_grant] = !r_out.valid || out_ready;
        ARB_FLUSH: in_ready[r_grant] = 1'b1;
        default:   in_ready = '0;
      endcase
    end
  end

  assign w_cur     = in[r_grant];
  assign w_accept  = w_cur.valid && in_ready[r_grant];
  assign w_load    = (r_state == ARB_BUSY) && w_accept;
  assign w_last    = (r_beat == BW'(MAX_BEATS - 1));
  assign w_mid_sop = w_load && w_cur.sop && (r_beat != '0);

  always_comb begin
    w_beat       = w_cur;
    w_beat.valid = 1'b1;
    if (r_beat != '0) w_beat.sop = 1'b0;
    if (!w_cur.eop && w_last) begin
      w_beat.eop   = 1'b1;
      w_beat.empty = '0;
    end
  end

  always_comb begin
    w_stray_cnt = '0;
    for (int i = 0; i < N_IN; i++) w_stray_cnt = w_stray_cnt + (PW + 1)'(w_stray[i]);
  end

  // Widened sum so several strays in one cycle still saturate instead of wrapping.
  assign w_err_inc  = (r_state == ARB_IDLE) ? w_stray_cnt : (PW + 1)'(w_mid_sop);
  assign w_err_sum  = SW'(r_err) + SW'(w_err_inc);
  assign w_err_next = (w_err_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_beat   <= '0;
      r_out    <= '0;
      r_busy   <= 1'b0;
      r_err    <= '0;
      r_trunc  <= '0;
    end else begin
      r_err <= w_err_next;
      if (w_load) r_out <= w_beat;
      else if (out_ready) r_out.valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant  <= w_pick;
            r_rr_ptr <= w_pick_next;
            r_beat   <= '0;
            r_state  <= ARB_BUSY;
            r_busy   <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (w_accept) begin
            r_beat <= r_beat + 1'b1;
            if (w_cur.eop) begin
              r_state <= ARB_IDLE;
              r_busy  <= 1'b0;
            end else if (w_last) begin
              if (r_trunc != '1) r_trunc <= r_trunc + 1'b1;
              r_state <= ARB_FLUSH;
            end
          end
        end
        ARB_FLUSH: begin
          if (w_accept && w_cur.eop) begin
            r_state <= ARB_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign grant_idx   = r_grant;
  assign busy        = r_busy;
  assign err_count   = r_err;
  assign trunc_count = r_trunc;

endmodule

// File: tb/tb_avln_st_arbiter.sv
// Scoreboard bench for avln_st_arbiter: per-source beat queues drive the inputs with
// handshake, expected output beats are queued at stimulus time and popped on out transfers.
module tb_avln_st_arbiter;
  import avln_st_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          out_ready = 1'b1;
  avln_st        in_s [N];
  logic [N-1:0]  in_ready;
  avln_st        out_s;
  logic [1:0]    grant_idx;
  logic          busy;
  logic [CW-1:0] err_count;
  logic [CW-1:0] trunc_count;

  avln_st src_q [N][$];
  avln_st exp_q [$];
  int     out_cyc [$];
  int     out_gnt [$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  always #5 clk = ~clk;

  avln_st_arbiter #(.N_IN(N), .MAX_BEATS(MB), .CNT_W(CW)) dut (
    .sys_clk     (clk),
    .reset       (reset),
    .in          (in_s),
    .in_ready    (in_ready),
    .out         (out_s),
    .out_ready   (out_ready),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .err_count   (err_count),
    .trunc_count (trunc_count)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic avln_st mk(input logic [31:0] d, input logic s, input logic e,
                                input logic [1:0] em);
    avln_st b;
    b.data = d; b.sop = s; b.eop = e; b.empty = em; b.valid = 1'b1;
    return b;
  endfunction

  function automatic int pending();
    int s = exp_q.size();
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  // Source driver and output monitor: drive on negedge, sample handshakes just before posedge.
  initial begin
    logic [N-1:0] fire;
    logic         mon;
    avln_st       seen;
    avln_st       e;
    for (int i = 0; i < N; i++) in_s[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) in_s[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      #4;
      for (int i = 0; i < N; i++) fire[i] = in_s[i].valid && in_ready[i];
      mon  = out_s.valid && out_ready;
      seen = out_s;
      if (mon) begin
        out_cyc.push_back(cyc);
        out_gnt.push_back(int'(grant_idx));
      end
      @(posedge clk);
      for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
      if (mon) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got data=%h sop=%b eop=%b empty=%0d, expected no beat",
                   seen.data, seen.sop, seen.eop, seen.empty);
        end else begin
          e = exp_q.pop_front();
          if (seen !== e) begin
            errors++;
            $display("FAIL out_beat: got data=%h sop=%b eop=%b empty=%0d, expected data=%h sop=%b eop=%b empty=%0d",
                     seen.data, seen.sop, seen.eop, seen.empty, e.data, e.sop, e.eop, e.empty);
          end
        end
      end
    end
  end

  task automatic push_pkt(input int src, input logic [31:0] base, input int n);
    for (int k = 1; k <= n; k++) begin
      avln_st b = mk(base + 32'(k), k == 1, k == n, (k == n) ? 2'd1 : 2'd0);
      src_q[src].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((pending() != 0 || busy || out_s.valid) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d busy=%b after %0d cycles, required pending=0 busy=0",
               name, pending(), busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (out_s !== '0) begin errors++; $display("FAIL reset_out: got %h, required 0", out_s); end
    checks++;
    if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++;
    if ({busy, grant_idx} !== 3'b000) begin
      errors++; $display("FAIL reset_busy_grant: got busy=%b grant=%0d, required 0/0", busy, grant_idx);
    end
    checks++;
    if ({err_count, trunc_count} !== '0) begin
      errors++; $display("FAIL reset_counters: got err=%0d trunc=%0d, required 0/0", err_count, trunc_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    out_cyc.delete(); out_gnt.delete();
    push_pkt(0, 32'h0000_0100, 3);
    push_pkt(2, 32'h0200_0100, 3);
    wait_drain("round_robin");
    checks++;
    if (out_cyc.size() != 6) begin
      errors++; $display("FAIL rr_beats: got %0d beats, required 6", out_cyc.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        int ec = c0 + 2 + k + ((k >= 3) ? 1 : 0);
        int eg = (k < 3) ? 0 : 2;
        checks++;
        if (out_cyc[k] != ec || out_gnt[k] != eg) begin
          errors++;
          $display("FAIL rr_timing beat %0d: got cycle=%0d grant=%0d, required cycle=%0d grant=%0d",
                   k, out_cyc[k], out_gnt[k], ec, eg);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    avln_st b2;
    int     n;
    push_pkt(1, 32'h0100_0300, 4);
    b2 = mk(32'h0100_0302, 1'b0, 1'b0, 2'd0);
    for (n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (out_s.valid && out_s.data == b2.data) break;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL bp_beat2_seen: got timeout, required beat 2 on out");
    end else begin
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #2;
        checks++;
        if (out_s !== b2) begin errors++; $display("FAIL bp_hold: got %h, required %h", out_s, b2); end
        checks++;
        if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready[1]); end
        @(negedge clk); #1;
      end
      out_ready = 1'b1;
    end
    wait_drain("backpressure");
  endtask

  task automatic test_truncation();
    for (int k = 1; k <= 7; k++) begin
      avln_st b = mk(32'h0100_0400 + 32'(k), k == 1, k == 7,
                     (k == 4) ? 2'd3 : ((k == 7) ? 2'd2 : 2'd0));
      src_q[1].push_back(b);
      if (k < 4) exp_q.push_back(b);
      else if (k == 4) exp_q.push_back(mk(b.data, 1'b0, 1'b1, 2'd0));
    end
    wait_drain("truncation");
    checks++;
    if (trunc_count !== 4'd1) begin errors++; $display("FAIL trunc_count: got %0d, required 1", trunc_count); end
    checks++;
    if (err_count !== 4'd0) begin errors++; $display("FAIL trunc_err: got %0d, required 0", err_count); end
    push_pkt(0, 32'h0000_0500, 2);
    wait_drain("after_trunc");
    checks++;
    if (trunc_count !== 4'd1) begin errors++; $display("FAIL trunc_after: got %0d, required 1", trunc_count); end
  endtask

  task automatic test_stray_sop();
    src_q[3].push_back(mk(32'h0300_0601, 1'b0, 1'b0, 2'd0));
    src_q[3].push_back(mk(32'h0300_0602, 1'b0, 1'b0, 2'd0));
    for (int k = 1; k <= 4; k++) begin
      src_q[3].push_back(mk(32'h0300_0610 + 32'(k), (k == 1) || (k == 3), k == 4, 2'd0));
      exp_q.push_back(mk(32'h0300_0610 + 32'(k), k == 1, k == 4, 2'd0));
    end
    wait_drain("stray_sop");
    checks++;
    if (err_count !== 4'd3) begin errors++; $display("FAIL stray_err: got %0d, required 3", err_count); end
  endtask

  task automatic test_single_beat();
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    out_cyc.delete(); out_gnt.delete();
    for (int i = 0; i < N; i++) begin
      avln_st b = mk(32'h0000_0700 + 32'(i), 1'b1, 1'b1, 2'd0);
      src_q[i].push_back(b);
      exp_q.push_back(b);
    end
    wait_drain("single_beat");
    checks++;
    if (out_cyc.size() != 4) begin
      errors++; $display("FAIL single_beats: got %0d beats, required 4", out_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_cyc[k] != c0 + 2 + 2 * k || out_gnt[k] != k) begin
          errors++;
          $display("FAIL single_timing beat %0d: got cycle=%0d grant=%0d, required cycle=%0d grant=%0d",
                   k, out_cyc[k], out_gnt[k], c0 + 2 + 2 * k, k);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++) src_q[i].push_back(mk(32'h0800_0000 + 32'(16 * i + k), 1'b0, 1'b0, 2'd0));
    wait_drain("saturation");
    checks++;
    if (err_count !== 4'hF) begin errors++; $display("FAIL err_saturate: got %0d, required 15", err_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 1; k <= 6; k++) begin
      avln_st b = mk(32'h0200_0900 + 32'(k), k == 1, k == 6, 2'd0);
      src_q[2].push_back(b);
      if (k <= 2) exp_q.push_back(b);
    end
    for (n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (out_s.valid && out_s.data == 32'h0200_0902) break;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL rst_mid_beat2_seen: got timeout, required beat 2 on out");
    end else begin
      reset = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (out_s.valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_state: got valid=%b busy=%b, required 0/0", out_s.valid, busy);
      end
      checks++;
      if ({err_count, trunc_count} !== '0) begin
        errors++; $display("FAIL rst_mid_counters: got err=%0d trunc=%0d, required 0/0", err_count, trunc_count);
      end
      checks++;
      if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_mid_grant: got %0d, required 0", grant_idx); end
      reset = 1'b0;
    end
    wait_drain("reset_mid");
    checks++;
    if (err_count !== 4'd4) begin errors++; $display("FAIL rst_tail_err: got %0d, required 4", err_count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_stray_sop();
    test_single_beat();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
